// File: rtl/audio_pkg.sv
// ============================================================================
// Package : audio_pkg
// Brief   : Shared widths and sample types for the audio-to-FFT stream path.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package audio_pkg;

  localparam int AXIS_WIDTH   = 32;
  localparam int SAMPLE_WIDTH = 24;
  localparam int OUT_WIDTH    = 16;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

  // Complex FFT input word: imaginary half on top, real sample below.
  typedef struct packed {
    logic [OUT_WIDTH-1:0] imag;
    logic [OUT_WIDTH-1:0] re;
  } fft_in_t;

endpackage

`default_nettype wire

// File: rtl/axis_sample_fifo.sv
// ============================================================================
// Module : axis_sample_fifo
// Brief  : Synchronous first-word-fall-through FIFO with wrap-bit pointers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_sample_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = OUT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_rd;
  logic             w_do_wr;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign dout    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_rd = rd_en && !empty;
  // A read on the same edge frees the slot, so a write while full is legal then.
  assign w_do_wr = wr_en && (!full || w_do_rd);

  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/audio_frame_packer.sv
// ============================================================================
// Module : audio_frame_packer
// Brief  : Picks (or mixes) an I2S channel, truncates to 16 bits and emits
//          fixed-length AXI4-Stream frames; drops on overflow, never stalls.
// Config : MONO_MIX_EN - average left/right pairs instead of left-only.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_frame_packer
  import audio_pkg::*;
#(
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic [AXIS_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [AXIS_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TLAST,
  output logic                  overflow
);

  localparam int             CW         = $clog2(FRAME_LEN);
  localparam logic [CW-1:0]  C_LAST_IDX = CW'(FRAME_LEN - 1);

  logic                 r_s_ready;
  logic                 r_conv_valid;
  logic [OUT_WIDTH-1:0] r_conv_data;
  logic                 r_overflow;
  logic [CW-1:0]        r_count;

  logic                 w_accept;
  logic                 w_cand_valid;
  logic [OUT_WIDTH-1:0] w_cand_data;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_rd;
  logic                 w_wr;
  logic [OUT_WIDTH-1:0] w_fifo_dout;
  fft_in_t              w_out;

  assign w_accept = S_AXIS_TVALID && r_s_ready;

`ifdef MONO_MIX_EN
  sample_t                 w_in;
  sample_t                 r_hold;
  logic                    r_hold_valid;
  logic [SAMPLE_WIDTH:0]   w_sum;
  logic                    w_unused_tdata;

  assign w_in           = S_AXIS_TDATA[AXIS_WIDTH-1 -: SAMPLE_WIDTH];
  assign w_unused_tdata = ^S_AXIS_TDATA[AXIS_WIDTH-SAMPLE_WIDTH-1:0];
  assign w_sum          = {r_hold[SAMPLE_WIDTH-1], r_hold} + {w_in[SAMPLE_WIDTH-1], w_in};
  assign w_cand_valid   = w_accept && S_AXIS_TLAST && r_hold_valid;
  // Bits [24:9] of the 25-bit sum are bits [23:8] of the arithmetic half.
  assign w_cand_data    = w_sum[SAMPLE_WIDTH -: OUT_WIDTH];

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      if (!S_AXIS_TLAST) begin
        r_hold       <= w_in;
        r_hold_valid <= 1'b1;
      end else begin
        r_hold_valid <= 1'b0;
      end
    end
  end
`else
  logic w_unused_tdata;

  assign w_unused_tdata = ^S_AXIS_TDATA[AXIS_WIDTH-OUT_WIDTH-1:0];
  assign w_cand_valid   = w_accept && !S_AXIS_TLAST;
  assign w_cand_data    = S_AXIS_TDATA[AXIS_WIDTH-1 -: OUT_WIDTH];
`endif

  assign w_rd = !w_empty && M_AXIS_TREADY;
  assign w_wr = r_conv_valid && (!w_full || w_rd);

  axis_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OUT_WIDTH)
  ) u_fifo (
    .clk   (S_AXIS_ACLK),
    .rst_n (S_AXIS_ARESETN),
    .wr_en (w_wr),
    .din   (r_conv_data),
    .full  (w_full),
    .rd_en (M_AXIS_TREADY),
    .empty (w_empty),
    .dout  (w_fifo_dout)
  );

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_s_ready    <= 1'b0;
      r_conv_valid <= 1'b0;
      r_conv_data  <= '0;
      r_overflow   <= 1'b0;
      r_count      <= '0;
    end else begin
      r_s_ready    <= 1'b1;
      r_conv_valid <= w_cand_valid;
      if (w_cand_valid) r_conv_data <= w_cand_data;
      if (r_conv_valid && w_full && !w_rd) r_overflow <= 1'b1;
      if (w_rd) r_count <= (r_count == C_LAST_IDX) ? '0 : r_count + CW'(1);
    end
  end

  // Data is forced to zero when empty so the idle bus matches the reset value.
  always_comb begin
    w_out = '0;
    if (!w_empty) w_out.re = w_fifo_dout;
  end

  assign S_AXIS_TREADY = r_s_ready;
  assign M_AXIS_TVALID = !w_empty;
  assign M_AXIS_TDATA  = w_out;
  assign M_AXIS_TLAST  = (r_count == C_LAST_IDX) && !w_empty;
  assign overflow      = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_audio_frame_packer.sv
// ============================================================================
// Module : tb_audio_frame_packer
// Brief  : Self-checking bench with a queue-based reference model; honours
//          MONO_MIX_EN when defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_frame_packer;

  localparam int FRAME_LEN  = 8;
  localparam int FIFO_DEPTH = 16;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic [31:0] s_data  = '0;
  logic        m_ready = 1'b0;
  logic        s_ready;
  logic        m_valid;
  logic        m_last;
  logic [31:0] m_data;
  logic        ovf;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] got_q[$];
  logic [15:0] exp_q[$];
  logic [23:0] mdl_hold = '0;
  bit          mdl_hv   = 1'b0;

  always #5 clk = ~clk;

  audio_frame_packer #(
    .FRAME_LEN  (FRAME_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .S_AXIS_ACLK    (clk),
    .S_AXIS_ARESETN (rst_n),
    .S_AXIS_TVALID  (s_valid),
    .S_AXIS_TREADY  (s_ready),
    .S_AXIS_TDATA   (s_data),
    .S_AXIS_TLAST   (s_last),
    .M_AXIS_TVALID  (m_valid),
    .M_AXIS_TREADY  (m_ready),
    .M_AXIS_TDATA   (m_data),
    .M_AXIS_TLAST   (m_last),
    .overflow       (ovf)
  );

  // Beats sampled mid-cycle complete on the following rising edge.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) got_q.push_back({m_last, m_data});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference: which input beats become output samples, and their values.
  task automatic model_beat(input logic [31:0] d, input logic l);
`ifdef MONO_MIX_EN
    int a, b, s;
    logic [31:0] sv;
    if (!l) begin
      mdl_hold = d[31:8];
      mdl_hv   = 1'b1;
    end else if (mdl_hv) begin
      a  = int'($signed(mdl_hold));
      b  = int'($signed(d[31:8]));
      s  = (a + b) >>> 1;
      sv = s;
      exp_q.push_back(sv[23:8]);
      mdl_hv = 1'b0;
    end
`else
    if (!l) exp_q.push_back(d[31:16]);
`endif
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    model_beat(d, l);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // One output sample: left beat, or an identical L/R pair when mixing.
  task automatic push_sample(input logic [15:0] v);
    send({v, 16'h0000}, 1'b0);
`ifdef MONO_MIX_EN
    send({v, 16'h0000}, 1'b1);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    m_ready = 1'b1;
    while (got_q.size() < exp_q.size() && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    idle(4);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    exp_q.delete();
    mdl_hv = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
    n_tests++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL rst_m_data got %h want 0", m_data); end
    n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL rst_m_last got %b want 0", m_last); end
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_overflow got %b want 0", ovf); end
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_tests++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL s_ready_before_edge got %b want 0", s_ready); end
    @(posedge clk); #1;
    n_tests++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL s_ready_after_edge got %b want 1", s_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    m_ready = 1'b1;
    send(32'h12345600, 1'b0);
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1 got valid %b want 0", m_valid); end
    send(32'hFFFFFF00, 1'b1);
    n_tests++; if ({m_valid, m_last, m_data} !== {2'b10, 32'h00001234}) begin
      n_fail++; $display("FAIL basic_lat2 got v%b l%b %h want v1 l0 00001234", m_valid, m_last, m_data);
    end
    idle(4);
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_right_dropped got valid %b want 0", m_valid); end
    n_tests++; if (got_q.size() != 1) begin n_fail++; $display("FAIL basic_beats got %0d want 1", got_q.size()); end
  endtask

`ifdef MONO_MIX_EN
  task automatic test_mix();
    do_reset();
    m_ready = 1'b1;
    send(32'h7FFFFF00, 1'b1);
    idle(3);
    n_tests++; if (got_q.size() != 0) begin n_fail++; $display("FAIL mix_orphan_right got %0d beats want 0", got_q.size()); end
    send(32'h7FFFFF00, 1'b0);
    send(32'h7FFFFF00, 1'b1);
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mix_lat1 got valid %b want 0", m_valid); end
    idle(1);
    n_tests++; if ({m_valid, m_data} !== {1'b1, 32'h00007FFF}) begin
      n_fail++; $display("FAIL mix_lat2 got v%b %h want v1 00007FFF", m_valid, m_data);
    end
    send(32'h80000000, 1'b0);
    send(32'h00000100, 1'b1);
    drain();
    n_tests++; if (got_q.size() != 2) begin n_fail++; $display("FAIL mix_beats got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      n_tests++; if (got_q[1] !== {1'b0, 32'h0000C000}) begin n_fail++; $display("FAIL mix_neg got %h want 0000c000", got_q[1]); end
    end
  endtask
`endif

  task automatic test_frames();
    logic [32:0] e;
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) push_sample(16'(k));
    drain();
    n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL frames_len got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (got_q[i]) if (i < exp_q.size()) begin
      e = {((i % FRAME_LEN) == FRAME_LEN - 1), 16'h0000, exp_q[i]};
      n_tests++; if (got_q[i] !== e) begin n_fail++; $display("FAIL frames[%0d] got %h want %h", i, got_q[i], e); end
    end
  endtask

  task automatic test_overflow();
    logic [32:0] e;
    do_reset();
    m_ready = 1'b0;
    for (int k = 0; k < FIFO_DEPTH; k++) push_sample(16'h0100 + 16'(k));
    idle(3);
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b want 0", ovf); end
    n_tests++; if ({m_valid, m_last, m_data} !== {2'b10, 32'h00000100}) begin
      n_fail++; $display("FAIL ovf_head got v%b l%b %h want v1 l0 00000100", m_valid, m_last, m_data);
    end
    for (int k = FIFO_DEPTH; k < FIFO_DEPTH + 3; k++) push_sample(16'h0100 + 16'(k));
    idle(3);
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", ovf); end
    while (exp_q.size() > FIFO_DEPTH) void'(exp_q.pop_back());
    drain();
    for (int k = 0; k < 8; k++) push_sample(16'h0200 + 16'(k));
    drain();
    n_tests++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL ovf_len got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (got_q[i]) if (i < exp_q.size()) begin
      e = {((i % FRAME_LEN) == FRAME_LEN - 1), 16'h0000, exp_q[i]};
      n_tests++; if (got_q[i] !== e) begin n_fail++; $display("FAIL ovf_seq[%0d] got %h want %h", i, got_q[i], e); end
    end
  endtask

  task automatic test_random_stall();
    logic [32:0] e;
    logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      m_ready = ($urandom_range(3) != 0);
      if ($urandom_range(3) == 0) begin
        s_valid = 1'b1;
        s_data  = $urandom;
        s_last  = 1'($urandom_range(1));
        model_beat(s_data, s_last);
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      if (pv && !pr) begin
        n_tests++;
        if ({m_valid, m_last, m_data} !== {1'b1, pl, pd}) begin
          n_fail++; $display("FAIL stall_hold cyc %0d got v%b l%b %h want v1 l%b %h", c, m_valid, m_last, m_data, pl, pd);
        end
      end
      pv = m_valid; pr = m_ready; pl = m_last; pd = m_data;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    drain();
    n_tests++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rand_ovf got %b want 0", ovf); end
    n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_len got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (got_q[i]) if (i < exp_q.size()) begin
      e = {((i % FRAME_LEN) == FRAME_LEN - 1), 16'h0000, exp_q[i]};
      n_tests++; if (got_q[i] !== e) begin n_fail++; $display("FAIL rand[%0d] got %h want %h", i, got_q[i], e); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [32:0] e;
    do_reset();
    m_ready = 1'b1;
    for (int k = 0; k < 5; k++) push_sample(16'h0300 + 16'(k));
    drain();
    n_tests++; if (got_q.size() != 5) begin n_fail++; $display("FAIL mid_pre_len got %0d want 5", got_q.size()); end
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_sample(16'h0400 + 16'(k));
    idle(3);
    n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pending got valid %b want 1", m_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if ({s_ready, m_valid, m_last, ovf, m_data} !== 36'h0) begin
      n_fail++; $display("FAIL mid_rst_outs got rdy%b v%b l%b o%b %h want all 0", s_ready, m_valid, m_last, ovf, m_data);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    exp_q.delete();
    mdl_hv  = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < FRAME_LEN; k++) push_sample(16'h0500 + 16'(k));
    drain();
    n_tests++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_len got %0d want %0d", got_q.size(), exp_q.size()); end
    foreach (got_q[i]) if (i < exp_q.size()) begin
      e = {((i % FRAME_LEN) == FRAME_LEN - 1), 16'h0000, exp_q[i]};
      n_tests++; if (got_q[i] !== e) begin n_fail++; $display("FAIL mid[%0d] got %h want %h", i, got_q[i], e); end
    end
  endtask

  initial begin
    test_reset();
`ifdef MONO_MIX_EN
    test_mix();
`else
    test_basic();
`endif
    test_frames();
    test_overflow();
    test_random_stall();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
